mdu_iter: RTL and testbench
===========================

# mdu_iter

Multi-cycle multiply/divide unit with HI/LO architectural registers, sitting in the EX stage of the five-stage pipeline beside the ALU. It accepts one operation per issue, holds `busy` for a fixed, parameterised number of cycles, and then commits the result to HI/LO. The hazard unit uses `start | busy` to stall any later MDU instruction, including mfhi/mflo/mthi/mtlo. Operand width and both latencies are parameters; an optional accumulate mode (madd/msub family) is compiled in by macro.

## Interface
- `WIDTH`, default 32: operand width and width of each of HI and LO.
- `MUL_CYCLES`, default 5: busy cycles for multiply-class ops (≥1).
- `DIV_CYCLES`, default 10: busy cycles for divide-class ops (≥1).
- `clk` in, 1 bit: single clock; all state changes on its rising edge.
- `reset` in, 1 bit: asynchronous, active-low; `reset`=0 clears all state immediately.
- `start` in, 1 bit: issue strobe, sampled on the rising edge.
- `op` in, 4 bits: operation code.
  - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU.
  - 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU.
  - 8–15 illegal.
- `a`, `b` in, `WIDTH` each: forwarded rs and rt operand values.
- `hi_we`, `lo_we` in, 1 bit each: mthi and mtlo write strobes.
- `wdata` in, `WIDTH`: data for mthi/mtlo.
- `busy` out, 1 bit: an operation is in flight.
- `done` out, 1 bit: one-cycle pulse in the first cycle the new HI/LO are visible.
- `hi`, `lo` out, `WIDTH` each: architectural HI and LO registers.

## Operation
- FSM has two states:
  - IDLE: `busy`=0.
  - RUN: `busy`=1; a down-counter of width `$clog2(max(MUL_CYCLES,DIV_CYCLES))+1` is active.
- Issue (IDLE, `start`=1, legal op):
  - Latch the result into the shadow registers `res_hi`/`res_lo`, computed at issue.
  - Load the counter with N = `MUL_CYCLES` or `DIV_CYCLES`.
  - Go to RUN.
- RUN:
  - The counter decrements every edge.
  - On the edge where the counter goes 1→0: commit `res_hi`/`res_lo` to `hi`/`lo`, set `done`=1 for one cycle, return to IDLE.
- Arithmetic:
  - MULT/MULTU: full 2·WIDTH product of signed/unsigned a×b, with {HI,LO} = product.
  - DIV/DIVU: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - Divide by zero: LO = all ones, HI = a.
  - Signed overflow (a = most-negative, b = −1): LO = a, HI = 0.
  - MADD/MADDU: {HI,LO} ← {HI,LO} + a×b, using the HI/LO values at issue; wraps modulo 2^(2·WIDTH).
  - MSUB/MSUBU: {HI,LO} ← {HI,LO} − a×b, same rules as MADD/MADDU.
- mthi/mtlo: when IDLE, `hi_we`/`lo_we` write `wdata` to HI/LO on the edge.
- Boundary conditions:
  - `start` while RUN: ignored. The hazard unit guarantees it does not happen.
  - `hi_we`/`lo_we` while RUN: ignored.
  - `start` and `hi_we`/`lo_we` in the same IDLE cycle: `start` wins and the write is dropped.
  - Illegal op, or op 4–7 without the macro: ignored; state stays IDLE, no `busy`, HI/LO unchanged.
  - `reset` asserted mid-operation: in-flight result discarded.
- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0, counter=0, shadows=0.

## Timing
- `start` sampled at edge T: `busy`=1 during cycles T+1 … T+N, exactly N cycles.
- Commit at edge T+N: `hi`/`lo` hold their new values and `done`=1 during cycle T+N+1, when `busy`=0.
- Back-to-back issue: a new `start` is accepted at edge T+N+1, giving a throughput of one op per N+1 cycles.
- `hi`/`lo` keep their old values throughout RUN.
- mthi/mtlo write latency: 1 edge.
- No combinational path from inputs to outputs.

## Configuration
- `MDU_MADD_EN` defined: ops 4–7 are legal and the accumulate datapath is built.
- `MDU_MADD_EN` undefined: ops 4–7 are illegal and ignored, and no accumulator adder is synthesised.
- Ops 0–3 behave identically in both builds.

## Test plan
- Reset then MULT, a=0xFFFFFFFE (−2), b=3 at edge T → `busy` high for 5 cycles; in cycle T+6, `done`=1, HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- DIVU a=100, b=7 → `busy` high for 10 cycles; then HI=2, LO=14.
- DIV a=−7, b=2 → HI=0xFFFFFFFF, LO=0xFFFFFFFD.
- DIV a=5, b=0 → LO=0xFFFFFFFF, HI=5.
- DIV a=0x80000000, b=0xFFFFFFFF → LO=0x80000000, HI=0.
- mthi 0x1, mtlo 0xFFFFFFFF, then MADDU a=1, b=1 (with the macro) → HI=2, LO=0 after 5 cycles.
  - Without the macro: `busy` stays 0 and HI/LO are unchanged.
- Corner sequence:
  - MULT issued, then at busy cycle 3 raise `start` and `hi_we` → both ignored; the MULT result commits on schedule.
  - Next MULT issued, then `reset` pulsed low in busy cycle 2 → `busy`=0 and HI=LO=0 immediately.

Source files
------------

// File: rtl/mdu_iter.sv
// Iterative-latency multiply/divide unit with HI/LO registers for the EX stage.
// Define MDU_MADD_EN to build the madd/msub accumulate ops (op codes 4-7).
module mdu_iter #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES) + 1;
    localparam logic [CW-1:0] MUL_N = CW'(MUL_CYCLES);
    localparam logic [CW-1:0] DIV_N = CW'(DIV_CYCLES);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, state_next;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   res_hi, res_lo;

    logic               is_signed, is_div, legal, issue;
    logic [2*WIDTH-1:0] a_ext, b_ext, prod, result;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag, divisor, q_mag, r_mag, quot, rem;

    assign is_signed = ~op[0];
    assign is_div    = (op[2:1] == 2'b01);
`ifdef MDU_MADD_EN
    assign legal     = ~op[3];
`else
    assign legal     = (op[3:2] == 2'b00);
`endif
    assign issue     = (state == IDLE) && start && legal;
    assign busy      = (state == RUN);

    assign a_ext = {{WIDTH{is_signed & a[WIDTH-1]}}, a};
    assign b_ext = {{WIDTH{is_signed & b[WIDTH-1]}}, b};
    assign prod  = a_ext * b_ext;

    // Divide on magnitudes, then restore signs; the most-negative / -1 case
    // falls out naturally as quotient = a, remainder = 0.
    assign a_neg   = is_signed & a[WIDTH-1];
    assign b_neg   = is_signed & b[WIDTH-1];
    assign a_mag   = a_neg ? -a : a;
    assign b_mag   = b_neg ? -b : b;
    assign divisor = (b == '0) ? WIDTH'(1) : b_mag;
    assign q_mag   = a_mag / divisor;
    assign r_mag   = a_mag % divisor;
    assign quot    = (a_neg ^ b_neg) ? -q_mag : q_mag;
    assign rem     = a_neg ? -r_mag : r_mag;

    always_comb begin
        result = prod;
        if (is_div) begin
            result = (b == '0) ? {a, {WIDTH{1'b1}}} : {rem, quot};
        end
`ifdef MDU_MADD_EN
        else if (op[2]) begin
            result = op[1] ? ({hi, lo} - prod) : ({hi, lo} + prod);
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (issue) state_next = RUN;
            RUN:     if (count == CW'(1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Results are computed at issue and held in shadows so HI/LO stay stable until commit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= '0;
            res_hi <= '0;
            res_lo <= '0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (issue) begin
                    res_hi <= result[2*WIDTH-1:WIDTH];
                    res_lo <= result[WIDTH-1:0];
                    count  <= is_div ? DIV_N : MUL_N;
                end else if (!start) begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                end
            end else begin
                count <= count - CW'(1);
                if (count == CW'(1)) begin
                    hi   <= res_hi;
                    lo   <= res_lo;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: expected HI/LO queued at issue, checked at done.
module tb_mdu_iter;

    localparam int W = 32;
`ifdef MDU_MADD_EN
    localparam bit MADD_ON = 1'b1;
`else
    localparam bit MADD_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset, start, hi_we, lo_we;
    logic [3:0]   op;
    logic [W-1:0] a, b, wdata;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int           total = 0;
    int           bad   = 0;
    logic [63:0]  sb_q[$];
    logic [W-1:0] cur_hi, cur_lo;

    always #5 clk = ~clk;

    mdu_iter #(.WIDTH(W), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Independent reference: native SV signed/unsigned arithmetic on 64-bit values.
    function automatic logic [63:0] refModel(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                             input logic [31:0] h, input logic [31:0] l);
        longint      sx, sy;
        logic [63:0] p;
        int          qi, ri;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (o[0]) p = {32'b0, x} * {32'b0, y};
        else      p = sx * sy;
        case (o)
            4'd0, 4'd1: return p;
            4'd2: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, x};
                qi = $signed(x) / $signed(y);
                ri = $signed(x) % $signed(y);
                return {ri, qi};
            end
            4'd3: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
            4'd4, 4'd5: return {h, l} + p;
            4'd6, 4'd7: return {h, l} - p;
            default: return {h, l};
        endcase
    endfunction

    task automatic applyStimulus(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                 input logic [63:0] exp, input string tag);
        int          n, cnt;
        bit          legal_op;
        logic [63:0] e;
        legal_op = (o < 4) || (MADD_ON && o < 8);
        n = (o[2:1] == 2'b01 && !o[3]) ? 10 : 5;
        op = o; a = x; b = y; start = 1'b1;
        if (legal_op) sb_q.push_back(exp);
        @(negedge clk);
        start = 1'b0;
        if (legal_op) begin
            checkOutput({tag, ".hold"}, {hi, lo}, {cur_hi, cur_lo});
            cnt = 0;
            while (busy && cnt < 50) begin
                cnt++;
                @(negedge clk);
            end
            checkOutput({tag, ".busy_cycles"}, 64'(cnt), 64'(n));
            checkOutput({tag, ".done"}, 64'(done), 64'd1);
            e = sb_q.pop_front();
            checkOutput({tag, ".hilo"}, {hi, lo}, e);
            cur_hi = e[63:32];
            cur_lo = e[31:0];
        end else begin
            checkOutput({tag, ".idle"}, {62'd0, busy, done}, 64'd0);
            checkOutput({tag, ".unchanged"}, {hi, lo}, {cur_hi, cur_lo});
        end
    endtask

    task automatic writeHiLo(input bit wh, input bit wl, input logic [31:0] d);
        hi_we = wh; lo_we = wl; wdata = d;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        if (wh) cur_hi = d;
        if (wl) cur_lo = d;
        checkOutput("mthi_mtlo", {hi, lo}, {cur_hi, cur_lo});
    endtask

    initial begin
        logic [3:0]  o;
        logic [31:0] x, y;
        logic [63:0] e;
        int          cnt;

        reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        cur_hi = '0; cur_lo = '0;
        #12;
        checkOutput("reset.busy", 64'(busy), 64'd0);
        checkOutput("reset.done", 64'(done), 64'd0);
        checkOutput("reset.hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        applyStimulus(4'd0, 32'hFFFF_FFFE, 32'd3, {32'hFFFF_FFFF, 32'hFFFF_FFFA}, "mult");
        applyStimulus(4'd3, 32'd100, 32'd7, {32'd2, 32'd14}, "divu");
        applyStimulus(4'd2, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "div_neg");
        applyStimulus(4'd2, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, "div_zero");
        applyStimulus(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, "div_ovf");
        applyStimulus(4'd3, 32'd9, 32'd0, {32'd9, 32'hFFFF_FFFF}, "divu_zero");
        applyStimulus(4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001}, "multu_max");

        writeHiLo(1'b1, 1'b0, 32'h1);
        writeHiLo(1'b0, 1'b1, 32'hFFFF_FFFF);
        applyStimulus(4'd5, 32'd1, 32'd1, {32'd2, 32'd0}, "maddu");
        applyStimulus(4'd9, 32'd3, 32'd4, 64'd0, "illegal");

        // start and mthi in the same idle cycle: the write must be dropped
        hi_we = 1'b1; wdata = 32'h1234_5678;
        applyStimulus(4'd0, 32'd3, 32'd4, {32'd0, 32'd12}, "start_vs_mthi");
        hi_we = 1'b0;

        for (int i = 0; i < 8; i++) begin
            o = 4'($urandom_range(0, MADD_ON ? 7 : 3));
            x = $urandom;
            y = (i % 4 == 3) ? 32'd0 : $urandom;
            e = refModel(o, x, y, cur_hi, cur_lo);
            applyStimulus(o, x, y, e, "random");
        end

        // start and mthi raised in busy cycle 3 are both ignored
        op = 4'd0; a = 32'd7; b = 32'd6; start = 1'b1;
        sb_q.push_back({32'd0, 32'd42});
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; op = 4'd3; hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0;
        checkOutput("corner.hold", {hi, lo}, {cur_hi, cur_lo});
        cnt = 3;
        while (busy && cnt < 50) begin
            cnt++;
            @(negedge clk);
        end
        checkOutput("corner.busy_cycles", 64'(cnt), 64'd5);
        checkOutput("corner.done", 64'(done), 64'd1);
        e = sb_q.pop_front();
        checkOutput("corner.hilo", {hi, lo}, e);
        cur_hi = e[63:32]; cur_lo = e[31:0];
        @(negedge clk);
        checkOutput("corner.no_second_op", {62'd0, busy, done}, 64'd0);

        // reset pulsed in busy cycle 2 discards the in-flight result
        op = 4'd0; a = 32'd3; b = 32'd5; start = 1'b1;
        sb_q.push_back({32'd0, 32'd15});
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("midreset.busy", 64'(busy), 64'd0);
        checkOutput("midreset.hilo", {hi, lo}, 64'd0);
        sb_q.delete();
        cur_hi = '0; cur_lo = '0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midreset.after", {62'd0, busy, done}, 64'd0);
        applyStimulus(4'd1, 32'd11, 32'd13, {32'd0, 32'd143}, "post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
